rf_writeback_arbiter: RTL

- Writer-side controller for the 32x32 integer register file write port (A3/WE/WD).
- Merges single-cycle ALU results with variable-latency load results, which arrive on a valid/ready handshake and are buffered in a small FIFO.
- Keeps a per-register busy scoreboard for outstanding loads.
- Supplies same-cycle bypass for the in-flight write, because register-file reads are combinational and show the old value until the write edge.

---
 rtl/rf_writeback_arbiter_if.sv | 48 ++++
 rtl/rf_writeback_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_arbiter_if
// Description : ALU/LSU writeback handshakes, load issue, decode queries and
//               register-file write port of the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_writeback_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  q1_addr;
    logic [4:0]  q2_addr;
    logic        q1_busy;
    logic        q2_busy;
    logic        q1_byp;
    logic        q2_byp;
    logic [31:0] byp_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, q1_addr, q2_addr,
        output alu_ready, lsu_ready,
        output q1_busy, q2_busy, q1_byp, q2_byp, byp_data,
        output rf_we, rf_a3, rf_wd
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, q1_addr, q2_addr,
        input  alu_ready, lsu_ready,
        input  q1_busy, q2_busy, q1_byp, q2_byp, byp_data,
        input  rf_we, rf_a3, rf_wd
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_arbiter
// Description : Register-file write-port arbiter: ALU results vs buffered load
//               results, load busy scoreboard and same-cycle write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter #(
    parameter int LSU_FIFO_DEPTH = 2,
    parameter int STARVE_MAX     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rf_writeback_arbiter_if.slave bus
);
    localparam int c_ptr_w = (LSU_FIFO_DEPTH > 1) ? $clog2(LSU_FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(LSU_FIFO_DEPTH + 1);
    localparam int c_stv_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_full     = c_cnt_w'(LSU_FIFO_DEPTH);
    localparam logic [c_stv_w-1:0] c_stv_max  = c_stv_w'(STARVE_MAX);

    logic [4:0]          fifo_rd_q   [LSU_FIFO_DEPTH];
    logic [31:0]         fifo_data_q [LSU_FIFO_DEPTH];
    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]  count_q, count_d;
    logic [c_stv_w-1:0]  stv_q, stv_d;
    logic                we_q, we_d;
    logic                ld_q, ld_d;
    logic [4:0]          a3_q, a3_d;
    logic [31:0]         wd_q, wd_d;
    logic [31:0]         busy_q, busy_d;

    logic                w_full;
    logic                w_nonempty;
    logic                w_alu_ready;
    logic                w_alu_win;
    logic                w_push;
    logic                w_pop;
    logic                w_sel;
    logic [4:0]          w_sel_rd;
    logic [31:0]         w_sel_data;

    always_comb begin
        w_full      = (count_q == c_full);
        w_nonempty  = (count_q != '0);
        // Throttle the ALU once the waiting head has lost STARVE_MAX times.
        w_alu_ready = !(w_nonempty && (stv_q == c_stv_max));
        w_alu_win   = bus.alu_valid && w_alu_ready;
        w_pop       = !w_alu_win && w_nonempty;
        w_push      = bus.lsu_valid && !w_full;
        w_sel       = w_alu_win || w_pop;
        w_sel_rd    = w_alu_win ? bus.alu_rd   : fifo_rd_q[rd_ptr_q];
        w_sel_data  = w_alu_win ? bus.alu_data : fifo_data_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stv_d    = stv_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_cnt_w'(1);
        end
        if (!w_nonempty || w_pop) begin
            stv_d = '0;
        end else if (w_alu_win) begin
            stv_d = stv_q + c_stv_w'(1);
        end
    end

    // x0 targets are consumed and still move A3/WD, but never raise WE.
    always_comb begin
        we_d = w_sel && (w_sel_rd != 5'd0);
        ld_d = w_pop;
        a3_d = w_sel ? w_sel_rd   : a3_q;
        wd_d = w_sel ? w_sel_data : wd_q;
    end

    // Clear on load commit first so a same-cycle re-issue keeps the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we_q && ld_q) begin
            busy_d[a3_q] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_rd_q[wr_ptr_q]   <= bus.lsu_rd;
            fifo_data_q[wr_ptr_q] <= bus.lsu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stv_q    <= '0;
            we_q     <= 1'b0;
            ld_q     <= 1'b0;
            a3_q     <= 5'd0;
            wd_q     <= 32'd0;
            busy_q   <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stv_q    <= stv_d;
            we_q     <= we_d;
            ld_q     <= ld_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.lsu_ready = !w_full;
    assign bus.rf_we     = we_q;
    assign bus.rf_a3     = a3_q;
    assign bus.rf_wd     = wd_q;
    assign bus.byp_data  = wd_q;
    assign bus.q1_busy   = busy_q[bus.q1_addr];
    assign bus.q2_busy   = busy_q[bus.q2_addr];
    assign bus.q1_byp    = we_q && (a3_q == bus.q1_addr) && (bus.q1_addr != 5'd0);
    assign bus.q2_byp    = we_q && (a3_q == bus.q2_addr) && (bus.q2_addr != 5'd0);

endmodule
`default_nettype wire
